// File: rtl/reg40_wr_arbiter_pkg.sv
// Shared definitions for the 40-word register-file write arbiter:
// geometry constants and the address range check.
package reg40_wr_arbiter_pkg;

  localparam int NUM_WORDS = 40;
  localparam int ADDR_W    = 6;
  localparam int NUM_REQ   = 4;
  localparam int REQ_IDX_W = 2;

  typedef logic [ADDR_W-1:0]    waddr_t;
  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  function automatic logic addr_in_range(input waddr_t a);
    return (a < ADDR_W'(NUM_WORDS));
  endfunction

endpackage

// File: rtl/reg40_wr_rr_pick.sv
// Rotating two-grant picker: scans valid buffers from rr_ptr upward and picks
// the first for port 0 and the next one with a different address for port 1.
module reg40_wr_rr_pick
  import reg40_wr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]             valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] addrs,
  input  req_idx_t                       rr_ptr,
  output req_idx_t                       grant0_idx,
  output logic                           grant0_vld,
  output req_idx_t                       grant1_idx,
  output logic                           grant1_vld
);

  // Same-address entries behind the port-0 winner are passed over, not granted.
  always_comb begin
    req_idx_t idx;
    logic     is_first;
    logic     is_second;
    grant0_idx = '0;
    grant0_vld = 1'b0;
    grant1_idx = '0;
    grant1_vld = 1'b0;
    idx        = '0;
    is_first   = 1'b0;
    is_second  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx       = req_idx_t'(rr_ptr + REQ_IDX_W'(k));
      is_first  = valid[idx] & ~grant0_vld;
      is_second = valid[idx] & grant0_vld & ~grant1_vld &
                  (addrs[idx] != addrs[grant0_idx]);
      if (is_first) begin
        grant0_vld = 1'b1;
        grant0_idx = idx;
      end else if (is_second) begin
        grant1_vld = 1'b1;
        grant1_idx = idx;
      end else begin
        grant1_vld = grant1_vld;
      end
    end
  end

endmodule

// File: rtl/reg40_wr_arbiter.sv
// Four-requester write arbiter onto a 2-port, 40-word register file.
// Optional macro REG40_WR_COLL_CNT_EN adds the saturating coll_cnt output.
module reg40_wr_arbiter
  import reg40_wr_arbiter_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       wr0_en,
  output logic [ADDR_W-1:0]          wr0_addr,
  output logic [WIDTH-1:0]           wr0_data,
  output logic                       wr1_en,
  output logic [ADDR_W-1:0]          wr1_addr,
  output logic [WIDTH-1:0]           wr1_data,
  output logic                       err_addr,
  output logic                       busy
`ifdef REG40_WR_COLL_CNT_EN
  ,
  output logic [15:0]                coll_cnt
`endif
);

  logic [NUM_REQ-1:0]             buf_valid_q, buf_valid_d;
  logic [NUM_REQ-1:0][ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [NUM_REQ-1:0][WIDTH-1:0]  buf_data_q, buf_data_d;
  req_idx_t                       rr_ptr_q, rr_ptr_d;
  logic                           wr0_en_q, wr0_en_d, wr1_en_q, wr1_en_d;
  logic [ADDR_W-1:0]              wr0_addr_q, wr0_addr_d, wr1_addr_q, wr1_addr_d;
  logic [WIDTH-1:0]               wr0_data_q, wr0_data_d, wr1_data_q, wr1_data_d;
  logic                           err_addr_q, err_addr_d;

  req_idx_t           g0_idx, g1_idx;
  logic               g0_vld, g1_vld, g0_ok, g1_ok;
  logic [NUM_REQ-1:0] drain, load;

  reg40_wr_rr_pick u_pick (
    .valid      (buf_valid_q),
    .addrs      (buf_addr_q),
    .rr_ptr     (rr_ptr_q),
    .grant0_idx (g0_idx),
    .grant0_vld (g0_vld),
    .grant1_idx (g1_idx),
    .grant1_vld (g1_vld)
  );

  assign req_ready = ~buf_valid_q | drain;

  // Buffer refill, write-port staging, pointer rotation and error capture.
  // An out-of-range grant still empties its buffer but never drives a write.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      drain[i] = (g0_vld & (g0_idx == REQ_IDX_W'(i))) |
                 (g1_vld & (g1_idx == REQ_IDX_W'(i)));
    end
    load = req_valid & (~buf_valid_q | drain);
    for (int i = 0; i < NUM_REQ; i++) begin
      buf_valid_d[i] = load[i] | (buf_valid_q[i] & ~drain[i]);
      buf_addr_d[i]  = load[i] ? req_addr[i*ADDR_W +: ADDR_W] : buf_addr_q[i];
      buf_data_d[i]  = load[i] ? req_data[i*WIDTH +: WIDTH] : buf_data_q[i];
    end
    g0_ok      = g0_vld & addr_in_range(buf_addr_q[g0_idx]);
    g1_ok      = g1_vld & addr_in_range(buf_addr_q[g1_idx]);
    wr0_en_d   = g0_ok;
    wr0_addr_d = g0_ok ? buf_addr_q[g0_idx] : {ADDR_W{1'b0}};
    wr0_data_d = g0_ok ? buf_data_q[g0_idx] : {WIDTH{1'b0}};
    wr1_en_d   = g1_ok;
    wr1_addr_d = g1_ok ? buf_addr_q[g1_idx] : {ADDR_W{1'b0}};
    wr1_data_d = g1_ok ? buf_data_q[g1_idx] : {WIDTH{1'b0}};
    rr_ptr_d   = g1_vld ? req_idx_t'(g1_idx + 2'd1) :
                 g0_vld ? req_idx_t'(g0_idx + 2'd1) : rr_ptr_q;
    err_addr_d = err_addr_q | (g0_vld & ~g0_ok) | (g1_vld & ~g1_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= '0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      rr_ptr_q    <= '0;
      wr0_en_q    <= 1'b0;
      wr0_addr_q  <= '0;
      wr0_data_q  <= '0;
      wr1_en_q    <= 1'b0;
      wr1_addr_q  <= '0;
      wr1_data_q  <= '0;
      err_addr_q  <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      rr_ptr_q    <= rr_ptr_d;
      wr0_en_q    <= wr0_en_d;
      wr0_addr_q  <= wr0_addr_d;
      wr0_data_q  <= wr0_data_d;
      wr1_en_q    <= wr1_en_d;
      wr1_addr_q  <= wr1_addr_d;
      wr1_data_q  <= wr1_data_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign wr0_en   = wr0_en_q;
  assign wr0_addr = wr0_addr_q;
  assign wr0_data = wr0_data_q;
  assign wr1_en   = wr1_en_q;
  assign wr1_addr = wr1_addr_q;
  assign wr1_data = wr1_data_q;
  assign err_addr = err_addr_q;
  assign busy     = (|buf_valid_q) | wr0_en_q | wr1_en_q;

`ifdef REG40_WR_COLL_CNT_EN
  logic        coll_s;
  logic [15:0] coll_cnt_q, coll_cnt_d;

  // Any other valid buffer sharing the port-0 address was skipped this cycle.
  always_comb begin
    coll_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      coll_s = coll_s | (buf_valid_q[i] & g0_vld & (g0_idx != REQ_IDX_W'(i)) &
                         (buf_addr_q[i] == buf_addr_q[g0_idx]));
    end
    coll_cnt_d = (coll_s && (coll_cnt_q != 16'hFFFF)) ? coll_cnt_q + 16'd1 : coll_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_cnt_q <= 16'd0;
    end else begin
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign coll_cnt = coll_cnt_q;
`endif

endmodule

// File: tb/tb_reg40_wr_arbiter.sv
// Self-checking bench for reg40_wr_arbiter: vector table, directed corner
// sequences, and a randomized run checked by a per-requester scoreboard.
module tb_reg40_wr_arbiter;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [23:0]   req_addr;
  logic [4*W-1:0] req_data;
  logic [3:0]    req_ready;
  logic          wr0_en, wr1_en, err_addr, busy;
  logic [5:0]    wr0_addr, wr1_addr;
  logic [W-1:0]  wr0_data, wr1_data;
`ifdef REG40_WR_COLL_CNT_EN
  logic [15:0]   coll_cnt;
`endif

  always #5 clk = ~clk;

  reg40_wr_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .err_addr(err_addr), .busy(busy)
`ifdef REG40_WR_COLL_CNT_EN
    , .coll_cnt(coll_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         req;
    logic [5:0] addr;
    logic [63:0] data;
    logic       exp_en;
    logic [5:0] exp_addr;
    logic [63:0] exp_data;
    logic       exp_err;
  } vec_t;

  typedef struct {
    int          id;
    logic [5:0]  addr;
    logic [63:0] data;
  } ent_t;

  ent_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [5:0] a, input logic [63:0] d);
    req_valid[i]          = 1'b1;
    req_addr[i*6 +: 6]    = a;
    req_data[i*W +: W]    = d;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_addr  = '0;
    req_data  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Match an observed write against the oldest pending entry of its requester;
  // out-of-range entries ahead of it must have been dropped silently.
  task automatic observe(input string nm, input logic en, input logic [5:0] a,
                         input logic [63:0] d);
    int  id;
    int  j;
    bit  done;
    id   = int'(d[63:62]);
    done = 1'b0;
    if (en) begin
      for (int it = 0; it < 64 && !done; it++) begin
        j = -1;
        for (int k = 0; k < sb.size(); k++) begin
          if (j < 0 && sb[k].id == id) j = k;
        end
        if (j < 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s_unexpected: got write addr %0d data %0h, required no write", nm, a, d);
          done = 1'b1;
        end else if (sb[j].addr >= 6'd40) begin
          sb.delete(j);
        end else begin
          chk({nm, "_addr"}, 64'(a), 64'(sb[j].addr));
          chk({nm, "_data"}, d, sb[j].data);
          sb.delete(j);
          done = 1'b1;
        end
      end
    end else begin
      chk({nm, "_idle_addr"}, 64'(a), 64'd0);
      chk({nm, "_idle_data"}, d, 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[6];
    logic [3:0]  acc;
    logic [5:0]  ra;
    int          seq;
    int          left;
    bit          any_bad;

    vt[0] = '{0, 6'd5,  64'hA5,        1'b1, 6'd5,  64'hA5,        1'b0};
    vt[1] = '{1, 6'd0,  64'h1111_0000, 1'b1, 6'd0,  64'h1111_0000, 1'b0};
    vt[2] = '{2, 6'd39, 64'hDEAD_BEEF, 1'b1, 6'd39, 64'hDEAD_BEEF, 1'b0};
    vt[3] = '{3, 6'd40, 64'h40,        1'b0, 6'd0,  64'd0,         1'b1};
    vt[4] = '{3, 6'd45, 64'h45,        1'b0, 6'd0,  64'd0,         1'b1};
    vt[5] = '{1, 6'd63, 64'h63,        1'b0, 6'd0,  64'd0,         1'b1};

    // Reset state.
    do_reset();
    chk("rst_wr0_en", 64'(wr0_en), 64'd0);
    chk("rst_wr0_addr", 64'(wr0_addr), 64'd0);
    chk("rst_wr0_data", wr0_data, 64'd0);
    chk("rst_wr1_en", 64'(wr1_en), 64'd0);
    chk("rst_wr1_addr", 64'(wr1_addr), 64'd0);
    chk("rst_wr1_data", wr1_data, 64'd0);
    chk("rst_err", 64'(err_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'hF);
`ifdef REG40_WR_COLL_CNT_EN
    chk("rst_coll_cnt", 64'(coll_cnt), 64'd0);
`endif

    // Single-transfer vectors: latency, range boundary, error flag.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      set_req(vt[v].req, vt[v].addr, vt[v].data);
      tick();
      req_valid = 4'b0000;
      chk("vec_early_en", 64'(wr0_en), 64'd0);
      chk("vec_busy", 64'(busy), 64'd1);
      tick();
      chk("vec_wr0_en", 64'(wr0_en), 64'(vt[v].exp_en));
      chk("vec_wr0_addr", 64'(wr0_addr), 64'(vt[v].exp_addr));
      chk("vec_wr0_data", wr0_data, vt[v].exp_data);
      chk("vec_wr1_en", 64'(wr1_en), 64'd0);
      chk("vec_err", 64'(err_addr), 64'(vt[v].exp_err));
      tick();
      chk("vec_after_en", 64'(wr0_en), 64'd0);
      chk("vec_after_busy", 64'(busy), 64'd0);
    end

    // Error flag is sticky across later good writes until reset.
    do_reset();
    set_req(3, 6'd45, 64'h45);
    tick();
    req_valid = 4'b0000;
    set_req(0, 6'd3, 64'h33);
    tick();
    req_valid = 4'b0000;
    chk("err_set", 64'(err_addr), 64'd1);
    chk("err_nowrite1", 64'(wr1_en), 64'd0);
    tick();
    chk("err_good_wr0", 64'(wr0_addr), 64'd3);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("err_sticky", 64'(err_addr), 64'd1);
    end
    do_reset();
    chk("err_cleared", 64'(err_addr), 64'd0);

    // Four simultaneous requests drain two per cycle, then rr_ptr back at 0.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 6'(i + 1), 64'(16 + i));
    tick();
    req_valid = 4'b0000;
    tick();
    chk("quad_a_wr0_addr", 64'(wr0_addr), 64'd1);
    chk("quad_a_wr0_data", wr0_data, 64'h10);
    chk("quad_a_wr1_addr", 64'(wr1_addr), 64'd2);
    chk("quad_a_wr1_data", wr1_data, 64'h11);
    tick();
    chk("quad_b_wr0_addr", 64'(wr0_addr), 64'd3);
    chk("quad_b_wr1_addr", 64'(wr1_addr), 64'd4);
    chk("quad_b_wr1_en", 64'(wr1_en), 64'd1);
    tick();
    chk("quad_c_idle", 64'({wr0_en, wr1_en}), 64'd0);
    set_req(0, 6'd8, 64'h80);
    set_req(2, 6'd9, 64'h90);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("rr0_wr0_addr", 64'(wr0_addr), 64'd8);
    chk("rr0_wr1_addr", 64'(wr1_addr), 64'd9);

    // Same-address collision: req1 first, req2 the following cycle.
    do_reset();
    set_req(1, 6'd7, 64'h71);
    set_req(2, 6'd7, 64'h72);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("coll_a_wr0_en", 64'(wr0_en), 64'd1);
    chk("coll_a_wr0_data", wr0_data, 64'h71);
    chk("coll_a_wr1_en", 64'(wr1_en), 64'd0);
    tick();
    chk("coll_b_wr0_addr", 64'(wr0_addr), 64'd7);
    chk("coll_b_wr0_data", wr0_data, 64'h72);
    chk("coll_b_wr1_en", 64'(wr1_en), 64'd0);
`ifdef REG40_WR_COLL_CNT_EN
    chk("coll_cnt", 64'(coll_cnt), 64'd1);
`endif
    tick();
    chk("coll_c_idle", 64'({wr0_en, wr1_en}), 64'd0);

    // Reset with three buffers pending discards them.
    do_reset();
    set_req(0, 6'd10, 64'hA);
    set_req(1, 6'd11, 64'hB);
    set_req(2, 6'd12, 64'hC);
    tick();
    req_valid = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'hF);
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst_no_wr", 64'({wr0_en, wr1_en}), 64'd0);
      tick();
    end

    // Streaming from req0: one write per cycle, in order, never stalled.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      set_req(0, 6'(k * 3 % 40), 64'h100 + 64'(k));
      chk("stream_ready", 64'(req_ready[0]), 64'd1);
      tick();
      if (k == 0) begin
        chk("stream_first_en", 64'(wr0_en), 64'd0);
      end else begin
        chk("stream_en", 64'(wr0_en), 64'd1);
        chk("stream_addr", 64'(wr0_addr), 64'((k - 1) * 3 % 40));
        chk("stream_data", wr0_data, 64'h100 + 64'(k - 1));
      end
    end
    req_valid = 4'b0000;
    tick();
    chk("stream_last_addr", 64'(wr0_addr), 64'(19 * 3 % 40));
    chk("stream_last_data", wr0_data, 64'h100 + 64'd19);
    tick();
    chk("stream_done", 64'(wr0_en), 64'd0);

    // Randomized traffic against the scoreboard.
    do_reset();
    sb.delete();
    seq     = 0;
    any_bad = 1'b0;
    for (int c = 0; c < 420; c++) begin
      observe("rnd_wr0", wr0_en, wr0_addr, wr0_data);
      observe("rnd_wr1", wr1_en, wr1_addr, wr1_data);
      if (wr0_en && wr1_en) chk("rnd_dual_same_addr", 64'(wr0_addr == wr1_addr), 64'd0);
      if (c < 400) begin
        for (int i = 0; i < 4; i++) begin
          ra = ($urandom_range(0, 9) == 0) ? 6'(40 + $urandom_range(0, 23))
                                          : 6'($urandom_range(0, 5));
          req_valid[i]       = ($urandom_range(0, 2) != 0);
          req_addr[i*6 +: 6] = ra;
          req_data[i*W +: W] = {2'(i), 30'd0, 32'(seq)};
          seq++;
        end
      end else begin
        req_valid = 4'b0000;
      end
      acc = req_valid & req_ready;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          sb.push_back('{i, req_addr[i*6 +: 6], req_data[i*W +: W]});
          if (req_addr[i*6 +: 6] >= 6'd40) any_bad = 1'b1;
        end
      end
      tick();
    end
    left = 0;
    foreach (sb[k]) if (sb[k].addr < 6'd40) left++;
    chk("rnd_undelivered", 64'(left), 64'd0);
    chk("rnd_busy_end", 64'(busy), 64'd0);
    chk("rnd_err", 64'(err_addr), 64'(any_bad));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg40_wr_arbiter.md
REG40_WR_ARBITER -- requirements
Module: reg40_wr_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 64, data width of each register word.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req_valid  input  4  per-requester write request valid.
REQ-005 SHALL have port: req_addr  input  4*6  per-requester word address; requester i owns bits [6i+5:6i].
REQ-006 SHALL have port: req_data  input  4*WIDTH  per-requester write data; requester i owns slice i.
REQ-007 SHALL have port: req_ready  output  4  per-requester accept; a transfer occurs when valid and ready are both high.
REQ-008 SHALL have ports: wr0_en / wr0_addr / wr0_data  output  1 / 6 / WIDTH  register-file write port 0, registered.
REQ-009 SHALL have ports: wr1_en / wr1_addr / wr1_data  output  1 / 6 / WIDTH  register-file write port 1, registered.
REQ-010 SHALL have port: err_addr  output  1  sticky flag; an out-of-range address (>=40) was accepted.
REQ-011 SHALL have port: busy  output  1  any holding buffer valid or any wr*_en high.

Function
REQ-012 SHALL hold one single-entry buffer (valid, addr, data) per requester, loaded on a transfer.
REQ-013 SHALL drive req_ready[i] = ~buf_valid[i] | grant[i], so back-to-back transfers per requester are sustained.
REQ-014 SHALL arbitrate each cycle over valid buffers, scanning from rr_ptr upward modulo 4: first valid -> port 0; next valid with addr != port-0 addr -> port 1.
REQ-015 SHALL never present wr0_en and wr1_en both high with wr0_addr == wr1_addr.
REQ-016 SHALL skip a buffer whose addr equals the port-0 grant addr (collision); it stays valid and competes next cycle.
REQ-017 SHALL register grants onto wr* outputs; latency is exactly 2 cycles from transfer edge to wr*_en high when uncontended.
REQ-018 SHALL drive wr*_addr and wr*_data to 0 when the corresponding wr*_en is low.
REQ-019 SHALL advance rr_ptr to (index of last granted requester + 1) mod 4 on any grant; rr_ptr is unchanged when no grant is made.
REQ-020 SHALL, for a buffer with addr >= 40, clear the buffer without a write (consuming no port) at its grant opportunity and set err_addr, which stays high until rst.
REQ-021 SHALL preserve per-requester write order; across requesters, same-address ordering follows grant order.
REQ-022 SHALL allow up to 2 grants per cycle; at most 2 of the 4 buffers drain per cycle.

Reset
REQ-023 SHALL on rst clear all buffers (pending writes discarded, including mid-operation), set rr_ptr=0, wr*_en=0, wr*_addr=0, wr*_data=0, err_addr=0, busy=0.
REQ-024 SHALL drive req_ready=4'b1111 in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with REG40_WR_COLL_CNT_EN defined, add output coll_cnt (16 bits, reset 0), incremented by 1 in each cycle where >=1 buffer is skipped per REQ-016, saturating at 16'hFFFF.
REQ-026 SHALL, without REG40_WR_COLL_CNT_EN, omit the coll_cnt port and counter, with all other behaviour identical.

Structure
REQ-027 SHALL place NUM_WORDS=40, ADDR_W=6 and NUM_REQ=4 in the shared definitions package.
REQ-028 SHALL implement the rotating two-grant picker as combinational sub-module reg40_wr_rr_pick, taking valid[3:0], addrs and rr_ptr and returning grant0/grant1 indices and valids.

Verification
REQ-029 SHALL test: single transfer req0 addr=5 data=0xA5 -> wr0_en=1, addr 5, data 0xA5 exactly 2 cycles later; wr1_en=0.
REQ-030 SHALL test: req0..req3 valid in the same cycle, addrs 1/2/3/4 -> one cycle grants req0/req1 on wr0/wr1, next cycle req2/req3; rr_ptr returns to 0.
REQ-031 SHALL test: req1 and req2 both addr=7 in the same cycle, rr_ptr=0 -> req1 written via wr0; req2 written the following cycle; no dual same-address write; coll_cnt=1 when the macro is enabled.
REQ-032 SHALL test: req3 addr=45 -> no wr*_en for it; err_addr=1 thereafter until rst.
REQ-033 SHALL test: 3 pending buffers, rst asserted one cycle -> no wr*_en afterwards; busy=0; req_ready=4'b1111.
REQ-034 SHALL test: req0 valid every cycle for 20 cycles, others idle -> 20 writes, one per cycle on wr0, in order, req_ready never low.
